// File: rtl/qspi_pkg.sv
// qspi_pkg: shared phase/lane types and helpers for the QSPI phase sequencer
// Holds the phase-state enum, the lane-mode enum, the per-lane-mode data shifts,
// and helpers that pick the data shift and the next non-empty phase.
package qspi_pkg;
  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_CMD   = 3'd1,
    PH_ADDR  = 3'd2,
    PH_DUMMY = 3'd3,
    PH_DATA  = 3'd4,
    PH_DONE  = 3'd5
  } phase_e;
  typedef enum logic [1:0] {
    LANE_SINGLE = 2'b00,
    LANE_DUAL   = 2'b01,
    LANE_QUAD   = 2'b10
  } lane_e;
  localparam logic [1:0] SHIFT_SINGLE = 2'd3;
  localparam logic [1:0] SHIFT_DUAL   = 2'd2;
  localparam logic [1:0] SHIFT_QUAD   = 2'd1;
  function automatic logic [1:0] lane_shift(input logic [1:0] lanes);
    return lanes == LANE_SINGLE ? SHIFT_SINGLE : lanes == LANE_DUAL ? SHIFT_DUAL : SHIFT_QUAD;
  endfunction
  // ne[i] flags a non-empty phase i+1 (CMD..DATA); the first one after cur wins, else DONE.
  function automatic phase_e next_phase(input phase_e cur, input logic [3:0] ne);
    next_phase = PH_DONE;
    for (int i = 3; i >= 0; i--) if (ne[i] && i + 1 > int'(cur)) next_phase = phase_e'(3'(i + 1));
  endfunction
endpackage

// File: rtl/qspi_phase_sequencer_if.sv
// qspi_phase_sequencer_if: control/status bundle of the QSPI phase sequencer
// master drives start, abort, phase lengths, lane mode (and hold when QSPI_SEQ_HOLD_EN
// is defined); slave returns busy, phase, beat_tick, phase_last, done, aborted, beats_left.
interface qspi_phase_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int PH_W  = 6
);
  import qspi_pkg::*;
  logic             start;
  logic             abort;
  logic [PH_W-1:0]  cmd_beats;
  logic [PH_W-1:0]  addr_beats;
  logic [PH_W-1:0]  dummy_beats;
  logic [CNT_W-1:0] data_bytes;
  logic [1:0]       data_lanes;
`ifdef QSPI_SEQ_HOLD_EN
  logic             hold;
`endif
  logic             busy;
  phase_e           phase;
  logic             beat_tick;
  logic             phase_last;
  logic             done;
  logic             aborted;
  logic [CNT_W+2:0] beats_left;
  modport master (
    output start, abort, cmd_beats, addr_beats, dummy_beats, data_bytes, data_lanes,
`ifdef QSPI_SEQ_HOLD_EN
    output hold,
`endif
    input  busy, phase, beat_tick, phase_last, done, aborted, beats_left
  );
  modport slave (
    input  start, abort, cmd_beats, addr_beats, dummy_beats, data_bytes, data_lanes,
`ifdef QSPI_SEQ_HOLD_EN
    input  hold,
`endif
    output busy, phase, beat_tick, phase_last, done, aborted, beats_left
  );
endinterface

// File: rtl/qspi_beat_down_counter.sv
// qspi_beat_down_counter: loadable, enabled down-counter with zero flag
// Ports: clk, rst_n (async active-low), i_load/i_load_val (load wins over enable),
// i_en (decrement), o_count (current value), o_zero (count == 0).
module qspi_beat_down_counter #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en) r_count <= r_count - W'(1);
  assign o_count = r_count;
  assign o_zero  = r_count == '0;
endmodule

// File: rtl/qspi_phase_sequencer.sv
// qspi_phase_sequencer: sequences QSPI CMD->ADDR->DUMMY->DATA->DONE phases by beat count
// Ports: clk, rst_n (async active-low), io_bus (qspi_phase_sequencer_if.slave) carrying
// start/abort/lengths/lane mode in and busy/phase/beat_tick/phase_last/done/aborted/beats_left out.
// Optional macro QSPI_SEQ_HOLD_EN adds io_bus.hold, which stalls beats in active phases.
module qspi_phase_sequencer
  import qspi_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PH_W  = 6
) (
  input logic                   clk,
  input logic                   rst_n,
  qspi_phase_sequencer_if.slave io_bus
);
  localparam int LW = CNT_W + 3;
  phase_e         r_state, w_next, w_adv;
  logic [LW-1:0]  r_len [4];
  logic [LW-1:0]  w_in_len [4];
  logic [LW-1:0]  w_src_len [4];
  logic [3:0]     w_ne;
  logic           w_idle, w_active, w_stall, w_accept, w_tick, w_last, w_load, w_zero;
  logic [LW-1:0]  w_load_val, w_count;
  assign w_in_len[0] = LW'(io_bus.cmd_beats);
  assign w_in_len[1] = LW'(io_bus.addr_beats);
  assign w_in_len[2] = LW'(io_bus.dummy_beats);
  assign w_in_len[3] = LW'(io_bus.data_bytes) << lane_shift(io_bus.data_lanes);
`ifdef QSPI_SEQ_HOLD_EN
  assign w_stall = io_bus.hold;
`else
  assign w_stall = 1'b0;
`endif
  assign w_idle   = r_state == PH_IDLE;
  assign w_active = r_state inside {PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA};
  assign w_accept = w_idle & io_bus.start & ~io_bus.abort;
  assign w_tick   = w_active & ~io_bus.abort & ~w_stall;
  assign w_last   = w_tick & w_zero;
  // In IDLE the first phase is chosen from the live inputs, otherwise from the latched copy.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_src_len[i] = w_idle ? w_in_len[i] : r_len[i];
      w_ne[i]      = w_src_len[i] != '0;
    end
  end
  assign w_adv = next_phase(r_state, w_ne);
  always_comb begin
    w_next = r_state;
    if (w_idle) w_next = w_accept ? w_adv : PH_IDLE;
    else if (r_state == PH_DONE || io_bus.abort) w_next = PH_IDLE;
    else if (w_last) w_next = w_adv;
    w_load     = w_next != r_state;
    w_load_val = w_next inside {PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA}
               ? w_src_len[2'(w_next - PH_CMD)] - LW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= PH_IDLE;
      r_len   <= '{default: '0};
    end else begin
      r_state <= w_next;
      if (w_accept) r_len <= w_in_len;
    end
  qspi_beat_down_counter #(.W(LW)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_en      (w_tick & ~w_zero),
    .o_count   (w_count),
    .o_zero    (w_zero)
  );
  assign io_bus.busy       = ~w_idle;
  assign io_bus.phase      = r_state;
  assign io_bus.beat_tick  = w_tick;
  assign io_bus.phase_last = w_last;
  assign io_bus.done       = r_state == PH_DONE;
  assign io_bus.aborted    = w_active & io_bus.abort;
  assign io_bus.beats_left = w_idle ? '0 : w_count;
endmodule

// File: tb/tb_qspi_phase_sequencer.sv
// tb_qspi_phase_sequencer: self-checking bench for qspi_phase_sequencer
module tb_qspi_phase_sequencer;
  import qspi_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  qspi_phase_sequencer_if #(.CNT_W(16), .PH_W(6)) bus ();
  qspi_phase_sequencer #(.CNT_W(16), .PH_W(6)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  typedef struct {
    int cmd; int addr; int dummy; int bytes; logic [1:0] lanes; int poke; int exp_total;
  } vec_t;
  typedef struct {phase_e ph; int bl0; int last_at;} ev_t;
  ev_t  sb[$];
  vec_t vecs[7];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input int c, input int a, input int d, input int b,
                       input logic [1:0] l, input logic s, input logic ab);
    bus.cmd_beats   = 6'(c);
    bus.addr_beats  = 6'(a);
    bus.dummy_beats = 6'(d);
    bus.data_bytes  = 16'(b);
    bus.data_lanes  = l;
    bus.start       = s;
    bus.abort       = ab;
  endtask
  // Called at a negedge; start is sampled at the next posedge (cycle n=1 is the first after it).
  task automatic run_xfer(input vec_t v);
    int len[4];
    int cum;
    int ticks;
    bit got_done;
    phase_e prev;
    ev_t cur;
    cum = 0; ticks = 0; got_done = 0; prev = PH_IDLE; cur = '{PH_IDLE, 0, 0};
    len[0] = v.cmd; len[1] = v.addr; len[2] = v.dummy;
    len[3] = v.bytes * (v.lanes == 2'b00 ? 8 : v.lanes == 2'b01 ? 4 : 2);
    for (int i = 0; i < 4; i++)
      if (len[i] > 0) begin
        cum += len[i];
        sb.push_back('{phase_e'(3'(i + 1)), len[i] - 1, cum});
      end
    drive(v.cmd, v.addr, v.dummy, v.bytes, v.lanes, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n <= v.exp_total + 4 && !got_done; n++) begin
      if (bus.phase != prev && bus.phase inside {PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA}) begin
        if (sb.size() == 0) chk("unexpected_phase", bus.phase, PH_IDLE);
        else begin
          cur = sb.pop_front();
          chk("phase_order", bus.phase, cur.ph);
          chk("entry_beats_left", bus.beats_left, cur.bl0);
        end
      end
      if (bus.beat_tick) ticks++;
      if (bus.phase_last) chk("phase_last_beat", ticks, cur.last_at);
      if (bus.aborted) chk("spurious_aborted", bus.aborted, 1'b0);
      if (bus.done) begin
        got_done = 1;
        chk("done_cycle", n, v.exp_total + 1);
        chk("tick_count", ticks, v.exp_total);
        chk("done_busy", bus.busy, 1'b1);
      end
      prev = bus.phase;
      if (n == v.poke) drive(63, 63, 63, 16'hFFFF, 2'b00, 1'b1, 1'b0);
      else if (n == v.poke + 1) bus.start = 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", got_done, 1'b1);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    chk("busy_after_done", bus.busy, 1'b0);
    chk("phase_after_done", bus.phase, PH_IDLE);
    chk("beats_left_idle", bus.beats_left, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int k;
    int ticks;
    int done_n;
    int seen;
    vecs[0] = '{8, 6, 4, 4, 2'b10, 0, 26};
    vecs[1] = '{8, 0, 0, 1, 2'b00, 0, 16};
    vecs[2] = '{0, 0, 0, 0, 2'b00, 0, 0};
    vecs[3] = '{0, 3, 0, 2, 2'b01, 2, 11};
    vecs[4] = '{1, 1, 1, 1, 2'b11, 0, 5};
    vecs[5] = '{0, 0, 5, 0, 2'b00, 6, 5};
    vecs[6] = '{3, 0, 0, 0, 2'b00, 1, 3};
    drive(0, 0, 0, 0, 2'b00, 1'b0, 1'b0);
`ifdef QSPI_SEQ_HOLD_EN
    bus.hold = 1'b0;
`endif
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_phase", bus.phase, PH_IDLE);
    chk("rst_tick", bus.beat_tick, 1'b0);
    chk("rst_last", bus.phase_last, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_aborted", bus.aborted, 1'b0);
    chk("rst_beats_left", bus.beats_left, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);
    drive(2, 0, 0, 0, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 0, 0, 0, 2'b00, 1'b0, 1'b0);
    chk("idle_abort_blocks_start", bus.busy, 1'b0);
    chk("idle_abort_phase", bus.phase, PH_IDLE);
    drive(2, 0, 0, 2, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (k = 0; k < 40 && !(bus.phase == PH_DATA && bus.beats_left == 13); k++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("reach_data_beat3", k, 4);
    chk("data_beat3_tick", bus.beat_tick, 1'b1);
    bus.abort = 1'b1;
    #1;
    chk("abort_ack", bus.aborted, 1'b1);
    chk("abort_no_done", bus.done | 1'(seen != 0), 1'b0);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_to_idle", bus.phase, PH_IDLE);
    chk("abort_busy_low", bus.busy, 1'b0);
    chk("abort_pulse_one", bus.aborted, 1'b0);
    run_xfer(vecs[1]);
    drive(0, 0, 0, 16'hFFFF, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("big_data_phase", bus.phase, PH_DATA);
    chk("big_data_beats_left", bus.beats_left, 19'h7FFF7);
    @(negedge clk);
    chk("big_data_decrement", bus.beats_left, 19'h7FFF6);
    bus.abort = 1'b1;
    #1;
    chk("big_abort_ack", bus.aborted, 1'b1);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("big_abort_idle", bus.phase, PH_IDLE);
    drive(0, 0, 0, 0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_state", bus.done, 1'b1);
    bus.abort = 1'b1;
    #1;
    chk("abort_in_done_done", bus.done, 1'b1);
    chk("abort_in_done_no_ack", bus.aborted, 1'b0);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("after_done_abort_idle", bus.busy, 1'b0);
    drive(10, 0, 0, 0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_phase", bus.phase, PH_IDLE);
    chk("async_rst_beats_left", bus.beats_left, 0);
    chk("async_rst_tick", bus.beat_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      if (bus.done || bus.aborted || bus.busy) seen++;
      @(negedge clk);
    end
    chk("no_activity_after_reset", seen, 0);
`ifdef QSPI_SEQ_HOLD_EN
    drive(4, 0, 0, 0, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    ticks = 0;
    done_n = 0;
    for (int n = 1; n <= 12 && done_n == 0; n++) begin
      bus.hold = n >= 2 && n <= 4;
      #1;
      if (bus.beat_tick) ticks++;
      if (n >= 2 && n <= 4) chk("hold_frozen_beats_left", bus.beats_left, 2);
      if (bus.done) done_n = n;
      @(negedge clk);
    end
    bus.hold = 1'b0;
    chk("hold_tick_count", ticks, 4);
    chk("hold_done_cycle", done_n, 8);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
